// File: rtl/tx_arb_if.sv
// Request/grant and transmitter-side signals of the serial transmit arbiter.
// master: the arbiter; slave: the requesters plus transmitter as seen from outside.
interface tx_arb_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_line;
  logic              busy;
  logic              err_timeout;

  modport master (
    input  req, req_data, tx_line,
    output grant, done, tx_data, tx_start, busy, err_timeout
  );

  modport slave (
    output req, req_data, tx_line,
    input  grant, done, tx_data, tx_start, busy, err_timeout
  );
endinterface

// File: rtl/tx_arbiter.sv
// Shares one serial transmitter between NREQ requesters; round-robin by default,
// fixed lowest-index priority when TX_ARB_FIXED_PRIO_EN is defined.
module tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int CLKS_PER_BIT  = 5208,
  parameter int FRAME_BITS    = 10,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 1024
) (
  input  logic      sysclk,
  input  logic      rst_n,
  tx_arb_if.master  bus
);

  localparam int FRAME_LEN = FRAME_BITS * CLKS_PER_BIT;
  localparam int CNT_MAX_A = (FRAME_LEN > START_TIMEOUT) ? FRAME_LEN : START_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int PTR_W     = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_START,
    S_FRAME,
    S_GAP
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  rr_q;
  logic [PTR_W-1:0]  owner_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   done_q;
  logic [7:0]        tx_data_q;
  logic              tx_start_q;
  logic              busy_q;
  logic              err_q;

  logic              win_vld_d;
  logic [PTR_W-1:0]  win_idx_d;
  logic [NREQ-1:0]   win_oh_d;
  logic [7:0]        win_data_d;
  logic [PTR_W-1:0]  rr_d;

`ifdef TX_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_vld_d = 1'b1;
        win_idx_d = PTR_W'(i);
      end
    end
  end

  assign rr_d = '0;
`else
  logic [PTR_W:0] sum;

  // Offsets scanned from far to near, so the first set bit at/after rr_q wins.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    sum       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_q} + (PTR_W + 1)'(i);
      if (sum >= (PTR_W + 1)'(NREQ)) sum = sum - (PTR_W + 1)'(NREQ);
      if (bus.req[sum[PTR_W-1:0]]) begin
        win_vld_d = 1'b1;
        win_idx_d = sum[PTR_W-1:0];
      end
    end
  end

  assign rr_d = (win_idx_d == PTR_W'(NREQ - 1)) ? '0 : win_idx_d + 1'b1;
`endif

  always_comb begin
    win_data_d = 8'h00;
    for (int j = 0; j < NREQ; j++) begin
      if (win_idx_d == PTR_W'(j)) win_data_d = bus.req_data[8*j +: 8];
    end
  end

  assign win_oh_d = NREQ'(1) << win_idx_d;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_SYNC;
      cnt_q      <= '0;
      rr_q       <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      case (state_q)
        // The transmitter is not reset with us, so wait for a full idle bit time.
        S_SYNC: begin
          if (!bus.tx_line) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (win_vld_d) begin
            grant_q    <= win_oh_d;
            tx_data_q  <= win_data_d;
            tx_start_q <= 1'b1;
            owner_q    <= win_idx_d;
            rr_q       <= rr_d;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (!bus.tx_line) begin
            tx_start_q <= 1'b0;
            cnt_q      <= CNT_W'(1);
            state_q    <= S_FRAME;
          end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
            tx_start_q <= 1'b0;
            err_q      <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_SYNC;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // Data bits may be low here, so the line is deliberately ignored.
        S_FRAME: begin
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            done_q  <= NREQ'(1) << owner_q;
            cnt_q   <= '0;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (!bus.tx_line) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q      <= '0;
          tx_start_q <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= S_SYNC;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with a behavioural UART transmitter and receiver on the line.
module tb_tx_arbiter;

  localparam int NREQ          = 4;
  localparam int CLKS_PER_BIT  = 4;
  localparam int FRAME_BITS    = 10;
  localparam int GAP_CYCLES    = 2;
  localparam int START_TIMEOUT = 8;
  localparam int RX_FIRST      = CLKS_PER_BIT + CLKS_PER_BIT / 2 - 1;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b1;
  always #5 sysclk = ~sysclk;

  tx_arb_if #(.NREQ(NREQ)) bus ();

  tx_arbiter #(
    .NREQ         (NREQ),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FRAME_BITS   (FRAME_BITS),
    .GAP_CYCLES   (GAP_CYCLES),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Transmitter model: not affected by rst_n; tx_en=0 models a disconnected start input.
  logic       tx_en    = 1'b1;
  logic       txm_busy = 1'b0;
  logic [9:0] txm_sh   = 10'h3FF;
  int         txm_cyc  = 0;
  int         txm_bit  = 0;

  always @(posedge sysclk) begin
    if (!txm_busy) begin
      if (tx_en && bus.tx_start) begin
        txm_sh   <= {1'b1, bus.tx_data, 1'b0};
        txm_busy <= 1'b1;
        txm_cyc  <= 0;
        txm_bit  <= 0;
      end
    end else if (txm_cyc == CLKS_PER_BIT - 1) begin
      txm_cyc <= 0;
      if (txm_bit == FRAME_BITS - 1) begin
        txm_busy <= 1'b0;
      end else begin
        txm_bit <= txm_bit + 1;
        txm_sh  <= {1'b1, txm_sh[9:1]};
      end
    end else begin
      txm_cyc <= txm_cyc + 1;
    end
  end

  assign bus.tx_line = txm_busy ? txm_sh[0] : 1'b1;

  // Receiver: finds the start-bit fall and samples each bit mid-cell.
  logic       rx_prev = 1'b1;
  logic       rx_act  = 1'b0;
  int         rx_cnt  = 0;
  logic [7:0] rx_sh   = 8'h00;
  logic [7:0] rx_byte = 8'h00;

  always @(posedge sysclk) begin
    rx_prev <= bus.tx_line;
    if (!rx_act) begin
      if (rx_prev && !bus.tx_line) begin
        rx_act <= 1'b1;
        rx_cnt <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt >= RX_FIRST && ((rx_cnt - RX_FIRST) % CLKS_PER_BIT) == 0) begin
        if ((rx_cnt - RX_FIRST) / CLKS_PER_BIT < 8) begin
          rx_sh <= {bus.tx_line, rx_sh[7:1]};
        end else begin
          rx_byte <= rx_sh;
          rx_act  <= 1'b0;
        end
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 300) begin
      step();
      n++;
    end
    chk(tag, bus.busy, 0);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_grant"}, bus.grant, 0);
    chk({pfx, "_done"}, bus.done, 0);
    chk({pfx, "_tx_data"}, bus.tx_data, 8'h00);
    chk({pfx, "_tx_start"}, bus.tx_start, 0);
    chk({pfx, "_busy"}, bus.busy, 1);
    chk({pfx, "_err"}, bus.err_timeout, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_g [5];
    logic [7:0] exp_d [5];
    int n;
    int k;
    int ovl;
    int seen;
    logic done_seen;

`ifdef TX_ARB_FIXED_PRIO_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_d = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
`else
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
`endif

    bus.req      = '0;
    bus.req_data = '0;
    #1 rst_n = 1'b0;
    step();
    step();
    chk_reset_vals("rst");

    // SYNC needs 4 consecutive high cycles before IDLE.
    rst_n = 1'b1;
    repeat (3) step();
    chk("sync_busy_3", bus.busy, 1);
    step();
    chk("sync_busy_4", bus.busy, 0);

    // Single request, byte 0x35.
    bus.req_data[7:0] = 8'h35;
    bus.req           = 4'b0001;
    step();
    chk("t1_grant", bus.grant, 4'b0001);
    chk("t1_tx_start", bus.tx_start, 1);
    chk("t1_tx_data", bus.tx_data, 8'h35);
    chk("t1_busy", bus.busy, 1);
    bus.req = '0;
    step();
    chk("t1_grant_pulse", bus.grant, 0);
    chk("t1_start_held", bus.tx_start, 1);
    chk("t1_line_low", bus.tx_line, 0);
    n = 0;
    while (bus.done == 0 && n < 60) begin
      step();
      n++;
      if (n == 1) chk("t1_start_drop", bus.tx_start, 0);
    end
    chk("t1_done_lat", n, 40);
    chk("t1_done", bus.done, 4'b0001);
    chk("t1_data_hold", bus.tx_data, 8'h35);
    chk("t1_rx_byte", rx_byte, 8'h35);
    step();
    chk("t1_gap_busy", bus.busy, 1);
    step();
    chk("t1_gap_idle", bus.busy, 0);

    // All four requesting continuously, pointer restarted at 0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_idle("t2_idle_pre");
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req      = 4'b1111;
    k   = 0;
    ovl = 0;
    n   = 0;
    while (k < 5 && n < 600) begin
      step();
      n++;
      if (bus.grant != 0 && bus.done != 0) ovl++;
      if (bus.grant != 0) begin
        chk($sformatf("t2_grant%0d", k), bus.grant, exp_g[k]);
        chk($sformatf("t2_data%0d", k), bus.tx_data, exp_d[k]);
        k++;
        if (k == 5) bus.req = '0;
      end
    end
    chk("t2_grant_count", k, 5);
    chk("t2_overlap", ovl, 0);
    wait_idle("t2_idle_post");

    // Start input disconnected: line never falls.
    tx_en             = 1'b0;
    bus.req_data[7:0] = 8'h77;
    bus.req           = 4'b0001;
    step();
    chk("t3_grant", bus.grant, 4'b0001);
    bus.req   = '0;
    n         = 0;
    done_seen = 1'b0;
    while (!bus.err_timeout && n < 20) begin
      step();
      n++;
      if (bus.done != 0) done_seen = 1'b1;
    end
    chk("t3_err_lat", n, 8);
    chk("t3_err", bus.err_timeout, 1);
    chk("t3_start_drop", bus.tx_start, 0);
    chk("t3_busy", bus.busy, 1);
    step();
    chk("t3_err_pulse", bus.err_timeout, 0);
    step();
    step();
    chk("t3_sync_busy", bus.busy, 1);
    step();
    chk("t3_sync_idle", bus.busy, 0);
    chk("t3_no_done", done_seen, 0);
    tx_en = 1'b1;

    // Reset mid-frame of an all-zero byte; transmitter keeps sending.
    bus.req_data[15:8] = 8'h00;
    bus.req            = 4'b0010;
    step();
    chk("t4_grant", bus.grant, 4'b0010);
    bus.req = '0;
    n = 0;
    repeat (11) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t4_rst");
    step();
    n++;
    rst_n             = 1'b1;
    bus.req_data[7:0] = 8'h5A;
    bus.req           = 4'b0001;
    while (bus.grant == 0 && n < 80) begin
      step();
      n++;
    end
    chk("t4_regrant_lat", n, 42);
    chk("t4_regrant", bus.grant, 4'b0001);
    bus.req = '0;
    wait_idle("t4_idle");

    // Foreign 1-cycle pulse while busy is lost; own re-request is queued.
    bus.req_data[7:0] = 8'h3C;
    bus.req           = 4'b0001;
    step();
    chk("t5_grant", bus.grant, 4'b0001);
    bus.req = '0;
    n = 0;
    while (n < 100) begin
      if (n == 5) bus.req = 4'b0100;
      else if (n == 6) bus.req = 4'b0000;
      else if (n == 10) bus.req = 4'b0001;
      step();
      n++;
      if (bus.grant != 0) break;
    end
    chk("t5_requeue_lat", n, 44);
    chk("t5_requeue_grant", bus.grant, 4'b0001);
    chk("t5_rx_byte", rx_byte, 8'h3C);
    bus.req = '0;
    seen = 0;
    repeat (80) begin
      step();
      if (bus.grant != 0) seen++;
    end
    chk("t5_pulse_not_granted", seen, 0);
    chk("t5_idle", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
